// File: rtl/instruction_fetch.sv
// Instruction fetch sequencer: ADDR -> DATA -> ISSUE -> EXEC (-> HALT), paged PC with PSET/jump/vector.
// Define ROM_BANK1_EN to make PCB/NBP real bits (8K words); otherwise the bank bit is tied to 0.
module instruction_fetch #(
  parameter logic [12:0] RESET_PC = 13'h0100
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk_en,
  output logic [12:0] rom_addr,
  input  logic [11:0] rom_data,
  output logic [11:0] instr,
  output logic        instr_valid,
  input  logic        exec_done,
  input  logic        jump,
  input  logic [7:0]  jump_pcs,
  input  logic        pset,
  input  logic [4:0]  pset_np,
  input  logic        vector_load,
  input  logic [12:0] vector_pc,
  input  logic        halt_req,
  input  logic        wake,
  output logic [12:0] pc,
  output logic        halted
);
  typedef enum logic [2:0] {ADDR, DATA, ISSUE, EXEC, HALT} state_t;

  state_t      state, state_nx;
  logic [11:0] pc_low;   // {PCP,PCS}
  logic [3:0]  npp;
  logic        pcb, nbp;
  logic [12:0] pc_nx;
  logic [4:0]  np, np_nx;

  assign pc          = {pcb, pc_low};
  assign np          = {nbp, npp};
  assign rom_addr    = pc;
  assign instr_valid = (state == ISSUE);
  assign halted      = (state == HALT);

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    np_nx    = np;
    case (state)
      ADDR:  state_nx = DATA;
      DATA:  state_nx = ISSUE;
      ISSUE: begin
        pc_nx    = {pc[12:8], pc[7:0] + 8'd1};
        state_nx = EXEC;
      end
      EXEC: if (exec_done) begin
        if (vector_load) pc_nx = vector_pc;
        else if (jump)   pc_nx = {np, jump_pcs};
        // jump above used the old page; PSET only affects the next instruction
        np_nx    = pset ? pset_np : pc_nx[12:8];
        state_nx = halt_req ? HALT : ADDR;
      end
      HALT: if (wake) begin
        if (vector_load) begin
          pc_nx = vector_pc;
          np_nx = vector_pc[12:8];
        end
        state_nx = ADDR;
      end
      default: state_nx = ADDR;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ADDR;
      pc_low <= RESET_PC[11:0];
      npp    <= RESET_PC[11:8];
      instr  <= '0;
    end else if (clk_en) begin
      state  <= state_nx;
      pc_low <= pc_nx[11:0];
      npp    <= np_nx[3:0];
      if (state == DATA) instr <= rom_data;
    end
  end

`ifdef ROM_BANK1_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcb <= RESET_PC[12];
      nbp <= RESET_PC[12];
    end else if (clk_en) begin
      pcb <= pc_nx[12];
      nbp <= np_nx[4];
    end
  end
`else
  assign pcb = 1'b0;
  assign nbp = 1'b0;
  logic unused_bank;
  assign unused_bank = pc_nx[12] ^ np_nx[4];
`endif

endmodule
